signal_select_ctrl: RTL

Controller that sequences the two-input phase-signal selector (reference phase vs. feedback phase mux) so source changes never produce runt pulses. It synchronizes both phase inputs, waits for the outgoing source to be low, blanks the muxed output for a programmable gap, flips the select, and re-enables output once the incoming source is low. It sits between the configuration register bank (source request) and the selector/gating datapath.

---
 rtl/signal_select_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/signal_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : signal_select_ctrl
// Purpose  : Glitch-free sequencing of a two-input phase-signal selector
//            (reference phase vs. feedback phase). A source change waits for
//            the outgoing source to be low, blanks the muxed output for a
//            programmable gap, flips the select, then re-enables the output
//            once the incoming source is low.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES    synchronizer depth per phase input (>= 2)
//   GAP_CYCLES     blanking cycles between gate-off and select flip (>= 1)
//   TIMEOUT_CYCLES max cycles spent in either WAIT state (>= 4)
//   RESET_SEL      o_selector after reset (1 = i_phi_r, 0 = i_phi_p)
//   ACT_WINDOW     activity-monitor window in cycles (monitor build only)
// Ports
//   i_clk       in   clock, all logic on the rising edge
//   i_rst       in   synchronous reset, active-high
//   i_phi_r     in   reference phase signal (asynchronous)
//   i_phi_p     in   feedback phase signal (asynchronous)
//   i_req_sel   in   requested source, level (1 = i_phi_r)
//   o_selector  out  select input of the selector mux
//   o_gate_en   out  gate enable for the muxed signal (0 = held low)
//   o_busy      out  high whenever the controller is not idle
//   o_done      out  one-cycle pulse when a switch completes
//   o_timeout   out  sticky WAIT timeout flag, cleared when a switch starts
//   o_stale     out  selected source inactive (monitor build only, else 0)
// Build option
//   SIGSEL_ACTIVITY_MON_EN  when defined, adds the source activity monitor
//                           that drives o_stale.
// ============================================================================
module signal_select_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_SEL      = 0,
  parameter int ACT_WINDOW     = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_phi_r,
  input  logic i_phi_p,
  input  logic i_req_sel,
  output logic o_selector,
  output logic o_gate_en,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout,
  output logic o_stale
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("signal_select_ctrl: SYNC_STAGES must be >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("signal_select_ctrl: GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_chk_to
    $error("signal_select_ctrl: TIMEOUT_CYCLES must be >= 4");
  end
  if (GAP_CYCLES >= TIMEOUT_CYCLES) begin : g_chk_gap_to
    $error("signal_select_ctrl: GAP_CYCLES must be < TIMEOUT_CYCLES");
  end
  if (ACT_WINDOW < 2) begin : g_chk_act
    $error("signal_select_ctrl: ACT_WINDOW must be >= 2");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // One counter serves both the gap and the wait timeouts; GAP_CYCLES is
  // always smaller than TIMEOUT_CYCLES so this width covers both.
  localparam int                 c_CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic               c_RESET_SEL = (RESET_SEL != 0);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_OLD_LOW = 2'd1,
    S_GAP          = 2'd2,
    S_WAIT_NEW_LOW = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_r_q;
  logic [SYNC_STAGES-1:0] sync_p_q;
  logic                   w_phi_r_s;
  logic                   w_phi_p_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_r_q <= '0;
      sync_p_q <= '0;
    end else begin
      sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], i_phi_r};
      sync_p_q <= {sync_p_q[SYNC_STAGES-2:0], i_phi_p};
    end
  end

  assign w_phi_r_s = sync_r_q[SYNC_STAGES-1];
  assign w_phi_p_s = sync_p_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Switch sequencer
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               sel_q;
  logic               gate_q;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;

  logic               w_cur_src;
  logic               w_to_hit;
  logic               w_gap_end;

  // "Current source" follows the live select, so after the flip the WAIT_NEW
  // state automatically looks at the incoming source.
  assign w_cur_src = sel_q ? w_phi_r_s : w_phi_p_s;
  assign w_to_hit  = (cnt_q == c_TO_LAST);
  assign w_gap_end = (state_q == S_GAP) && (cnt_q == c_GAP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= c_RESET_SEL;
      gate_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The request is only looked at here; a request that reverts
          // mid-switch is picked up again once the current switch is done.
          if (i_req_sel != sel_q) begin
            state_q   <= S_WAIT_OLD_LOW;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        S_WAIT_OLD_LOW: begin
          if (!w_cur_src || w_to_hit) begin
            // Gate off while the outgoing source is low (or give up waiting).
            gate_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_GAP;
            if (w_cur_src) begin
              timeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_GAP: begin
          if (w_gap_end) begin
            // Gate is already off, so the select can change without a runt.
            sel_q   <= ~sel_q;
            cnt_q   <= '0;
            state_q <= S_WAIT_NEW_LOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WAIT_NEW_LOW: begin
          if (!w_cur_src || w_to_hit) begin
            gate_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (w_cur_src) begin
              timeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          gate_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_selector = sel_q;
  assign o_gate_en  = gate_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;

  // --------------------------------------------------------------------------
  // Source activity monitor
  // --------------------------------------------------------------------------
`ifdef SIGSEL_ACTIVITY_MON_EN
  localparam int                 c_ACT_W    = $clog2(ACT_WINDOW);
  localparam logic [c_ACT_W-1:0] c_ACT_LAST = c_ACT_W'(ACT_WINDOW - 1);

  logic               prev_r_q;
  logic               prev_p_q;
  logic [c_ACT_W-1:0] act_cnt_q;
  logic               stale_q;
  logic               w_rise;

  // Both edge detectors run all the time so the detector for the incoming
  // source is already primed when the select flips.
  assign w_rise = sel_q ? (w_phi_r_s & ~prev_r_q) : (w_phi_p_s & ~prev_p_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_r_q  <= 1'b0;
      prev_p_q  <= 1'b0;
      act_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else begin
      prev_r_q <= w_phi_r_s;
      prev_p_q <= w_phi_p_s;
      if (w_gap_end || w_rise) begin
        act_cnt_q <= '0;
        stale_q   <= 1'b0;
      end else if (act_cnt_q == c_ACT_LAST) begin
        // Window elapsed with no edge; counter holds until the next edge.
        stale_q <= 1'b1;
      end else begin
        act_cnt_q <= act_cnt_q + 1'b1;
      end
    end
  end

  assign o_stale = stale_q;
`else
  assign o_stale = 1'b0;
`endif

endmodule
`default_nettype wire
